// File: rtl/fifo_tx_serializer_if.sv
// Purpose : read-side handshake between the 10-bit FIFO and its serial
//           transmitter (fifo_tx_serializer).
// Signals : FIFO_EMPTY  FIFO Empty flag (FIFO -> serializer)
//           FIFO_DOUT   FIFO read data, valid from the edge that ends the
//                       RD_EN cycle (FIFO -> serializer)
//           FIFO_RD_EN  one-cycle pop request (serializer -> FIFO)
// Modports: master = serializer side, slave = FIFO side.
interface fifo_tx_serializer_if #(
  parameter int DATA_W = 10
) ();

  logic              FIFO_EMPTY;
  logic [DATA_W-1:0] FIFO_DOUT;
  logic              FIFO_RD_EN;

  modport master (
    input  FIFO_EMPTY,
    input  FIFO_DOUT,
    output FIFO_RD_EN
  );

  modport slave (
    output FIFO_EMPTY,
    output FIFO_DOUT,
    input  FIFO_RD_EN
  );

endinterface

// File: rtl/fifo_tx_serializer.sv
// Purpose : pops one word at a time from the FIFO and shifts it out on TX
//           as an asynchronous frame: start bit, DATA_W data bits LSB
//           first, optional even-parity bit, stop bit.
// Ports   : CLK        system clock, rising edge
//           RST        synchronous reset, active low
//           ENABLE     permits a new frame; only looked at in IDLE
//           fifo       FIFO read handshake (master modport)
//           TX         serial line, idles high
//           BUSY       high whenever the block is not idle
//           DONE       one-cycle pulse on the last cycle of the stop bit
// Option  : define TX_PARITY_EN to insert an even-parity bit between the
//           data bits and the stop bit.
// All outputs are registered: their next values are derived from the
// next-state values, so they line up with the state they belong to.
module fifo_tx_serializer #(
  parameter int DATA_W       = 10,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  fifo_tx_serializer_if.master fifo,
  output logic                 TX,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_BIT  = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]       clk_cnt_q, clk_cnt_d;
  logic                tx_q, tx_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // State register: all flops, including the registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      clk_cnt_q <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state and datapath. FIFO_DOUT is captured only in LOAD, so later
  // FIFO writes cannot disturb a frame in flight. The clock counter wraps
  // at the end of every serial bit; the bit counter only runs in DATA.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;
`ifdef TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (ENABLE && !fifo.FIFO_EMPTY) state_d = S_POP;
      end
      S_POP: state_d = S_LOAD;
      S_LOAD: begin
        shift_d   = fifo.FIFO_DOUT;
        bit_cnt_d = '0;
        clk_cnt_d = '0;
`ifdef TX_PARITY_EN
        parity_d  = ^fifo.FIFO_DOUT;
`endif
        state_d   = S_START;
      end
      S_START: begin
        if (clk_cnt_q == LAST_CLK) begin
          clk_cnt_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt_q == LAST_CLK) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_q == LAST_CLK) begin
          clk_cnt_d = '0;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt_q == LAST_CLK) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next-state values; the flops then present each
  // output in the same cycle as the state it belongs to.
  always_comb begin
    tx_d    = 1'b1;
    rd_en_d = (state_d == S_POP);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (clk_cnt_d == LAST_CLK);
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign TX              = tx_q;
  assign BUSY            = busy_q;
  assign DONE            = done_q;
  assign fifo.FIFO_RD_EN = rd_en_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Testbench for fifo_tx_serializer. A queue stands in for the FIFO; a
// reference model expands every popped word into its expected per-cycle
// waveform (LOAD cycle, start, data LSB first, optional parity, stop,
// one idle cycle) and every cycle is compared against it. A table of
// hand-encoded frames is checked mid-bit, followed by directed corner
// cases and a randomized run. Define TX_PARITY_EN to test the parity build.
module tb_fifo_tx_serializer;

  localparam int DATA_W = 10;
  localparam int CPB    = 4;
`ifdef TX_PARITY_EN
  localparam int NBITS  = DATA_W + 3;
`else
  localparam int NBITS  = DATA_W + 2;
`endif

  typedef struct packed {
    logic rd;
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  // Table record: word to send, its expected frame in time order
  // (bit 0 = start, bits 1..10 = data LSB first, bit 11 = stop) and the
  // expected even-parity bit.
  typedef struct {
    logic [DATA_W-1:0] word;
    logic [11:0]       frame;
    logic              par;
  } vec_t;

  localparam exp_t IDLE_EXP = '{rd: 1'b0, tx: 1'b1, busy: 1'b0, done: 1'b0};

  logic CLK, RST, ENABLE, TX, BUSY, DONE;
  fifo_tx_serializer_if #(.DATA_W(DATA_W)) ifc ();

  fifo_tx_serializer #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .ENABLE(ENABLE),
    .fifo  (ifc),
    .TX    (TX),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int rd_count = 0;
  int done_count = 0;
  int last_rd_cycle = 0;
  int last_done_cycle = 0;
  logic [DATA_W-1:0] fifo_q[$];
  exp_t exp_q[$];
  vec_t vecs[6];

  // Free-running 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: got %0h, required %0h", name, cycle, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en);
    RST    = rst;
    ENABLE = en;
  endtask

  task automatic pushWord(input logic [DATA_W-1:0] w);
    fifo_q.push_back(w);
    ifc.FIFO_EMPTY = 1'b0;
  endtask

  // Expected waveform of one popped word, starting with the LOAD cycle.
  task automatic pushFrame(input logic [DATA_W-1:0] w);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(w[i]);
`ifdef TX_PARITY_EN
    bits.push_back(^w);
`endif
    bits.push_back(1'b1);
    exp_q.push_back('{rd: 1'b0, tx: 1'b1, busy: 1'b1, done: 1'b0});
    foreach (bits[b])
      for (int k = 0; k < CPB; k++)
        exp_q.push_back('{rd: 1'b0, tx: bits[b], busy: 1'b1,
                          done: (b == bits.size() - 1) && (k == CPB - 1)});
    exp_q.push_back(IDLE_EXP);
  endtask

  // One clock: FIFO stand-in, reference model and per-cycle comparison.
  task automatic step();
    logic rd_before, en_before, empty_before, rst_before;
    logic [DATA_W-1:0] w;
    exp_t e;
    rd_before    = ifc.FIFO_RD_EN;
    en_before    = ENABLE;
    empty_before = ifc.FIFO_EMPTY;
    rst_before   = RST;
    w = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    @(posedge CLK);
    #1;
    cycle++;
    if (rd_before && fifo_q.size() > 0) ifc.FIFO_DOUT = fifo_q.pop_front();
    ifc.FIFO_EMPTY = (fifo_q.size() == 0);
    if (!rst_before) begin
      exp_q.delete();
      e = IDLE_EXP;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else if (en_before && !empty_before) begin
      e = '{rd: 1'b1, tx: 1'b1, busy: 1'b1, done: 1'b0};
      pushFrame(w);
    end else begin
      e = IDLE_EXP;
    end
    checkOutput("rd/tx/busy/done", int'({ifc.FIFO_RD_EN, TX, BUSY, DONE}), int'(e));
    if (ifc.FIFO_RD_EN) begin
      rd_count++;
      last_rd_cycle = cycle;
    end
    if (DONE) begin
      done_count++;
      last_done_cycle = cycle;
    end
  endtask

  task automatic waitRdEn(input int bound);
    int start;
    start = rd_count;
    for (int n = 0; n < bound && rd_count == start; n++) step();
    checkOutput("rd_en seen", int'(rd_count != start), 1);
  endtask

  task automatic waitIdle(input int bound);
    for (int n = 0; n < bound && !(exp_q.size() == 0 && fifo_q.size() == 0 && !BUSY); n++) step();
    checkOutput("reached idle", int'(exp_q.size() == 0 && fifo_q.size() == 0 && !BUSY), 1);
  endtask

  initial begin
    int rd0, d0;
    logic exp_bit;
    vecs[0] = '{word: 10'd32,   frame: 12'b1_0000100000_0, par: 1'b1};
    vecs[1] = '{word: 10'd53,   frame: 12'b1_0000110101_0, par: 1'b0};
    vecs[2] = '{word: 10'd29,   frame: 12'b1_0000011101_0, par: 1'b0};
    vecs[3] = '{word: 10'd7,    frame: 12'b1_0000000111_0, par: 1'b1};
    vecs[4] = '{word: 10'h3FF,  frame: 12'b1_1111111111_0, par: 1'b0};
    vecs[5] = '{word: 10'h000,  frame: 12'b1_0000000000_0, par: 1'b0};

    // Reset held for three edges with a word waiting and ENABLE high.
    ifc.FIFO_DOUT = '0;
    applyStimulus(1'b0, 1'b1);
    pushWord(10'h155);
    repeat (3) step();
    fifo_q.delete();
    ifc.FIFO_EMPTY = 1'b1;
    step();
    applyStimulus(1'b1, 1'b0);
    step();

    // Table: each word sent alone, TX sampled in the middle of every bit.
    foreach (vecs[v]) begin
      rd0 = rd_count;
      d0  = done_count;
      pushWord(vecs[v].word);
      applyStimulus(1'b1, 1'b1);
      waitRdEn(20);
      step();
      for (int b = 0; b < NBITS; b++) begin
        for (int k = 0; k < CPB; k++) begin
          step();
          if (k == CPB / 2) begin
            if (b <= DATA_W) exp_bit = vecs[v].frame[b];
            else if (b == NBITS - 1) exp_bit = vecs[v].frame[11];
            else exp_bit = vecs[v].par;
            checkOutput("frame bit", int'(TX), int'(exp_bit));
          end
        end
      end
      step();
      checkOutput("rd pulses per frame", rd_count - rd0, 1);
      checkOutput("done pulses per frame", done_count - d0, 1);
      // RD_EN rises at edge n; DONE covers the last cycle before edge n+50.
      checkOutput("done offset", last_done_cycle - last_rd_cycle, NBITS * CPB + 1);
    end

    // Three preloaded words back to back with ENABLE held high.
    applyStimulus(1'b1, 1'b0);
    step();
    rd0 = rd_count;
    d0  = done_count;
    pushWord(10'd32);
    pushWord(10'd29);
    pushWord(10'd53);
    applyStimulus(1'b1, 1'b1);
    waitIdle(400);
    checkOutput("three rd pulses", rd_count - rd0, 3);
    checkOutput("three done pulses", done_count - d0, 3);

    // Empty FIFO with ENABLE high: nothing may happen.
    rd0 = rd_count;
    repeat (100) step();
    checkOutput("no pop when empty", rd_count - rd0, 0);

    // Reset during the data bits of word 53, then release with FIFO empty.
    pushWord(10'd53);
    waitRdEn(20);
    repeat (1 + CPB + 3 * CPB + 2) step();
    applyStimulus(1'b0, 1'b1);
    step();
    checkOutput("tx after reset", int'(TX), 1);
    checkOutput("busy after reset", int'(BUSY), 0);
    applyStimulus(1'b1, 1'b1);
    rd0 = rd_count;
    d0  = done_count;
    repeat (100) step();
    checkOutput("no retry after reset", rd_count - rd0, 0);
    checkOutput("no done after reset", done_count - d0, 0);

    // Randomized traffic, ENABLE toggling and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) ENABLE = ($urandom_range(3) != 0);
      if ($urandom_range(39) == 0 && fifo_q.size() < 8) pushWord(DATA_W'($urandom));
      RST = ($urandom_range(499) != 0);
      step();
    end
    applyStimulus(1'b1, 1'b1);
    waitIdle(1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
Downstream consumer of the 10-bit FIFO. Pops one word at a time when the FIFO is not Empty and shifts it out on a single serial line as an asynchronous frame: start bit, 10 data bits LSB first, optional parity bit, stop bit. Sits between the FIFO's Dout/RD_EN/Empty interface and an off-block serial pin. Provides BUSY/DONE status for the controller.

Parameters:
DATA_W, 10, word width; matches FIFO Din/Dout.
CLKS_PER_BIT, 4, CLK cycles per serial bit; legal range ≥2.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  reset, synchronous, active-low (0 = reset).
ENABLE  in  1  allows starting a new frame; sampled only in IDLE.
FIFO_EMPTY  in  1  FIFO Empty flag.
FIFO_DOUT  in  DATA_W  FIFO Dout; valid from the edge that ends the RD_EN cycle.
FIFO_RD_EN  out  1  one-cycle pop request to FIFO.
TX  out  1  serial line; idle high.
BUSY  out  1  high in every state except IDLE.
DONE  out  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (RST=0 at rising edge): state IDLE; TX=1, FIFO_RD_EN=0, BUSY=0, DONE=0; shift register, bit counter, and clock counter cleared. Reset has priority over all other inputs.
- All outputs are registered, with no combinational path from input to output.
- States: IDLE, POP, LOAD, START, DATA, PARITY (only with the macro), STOP.
- IDLE: TX=1. If ENABLE=1 and FIFO_EMPTY=0, go to POP; otherwise stay in IDLE.
- POP: FIFO_RD_EN=1 for exactly this one cycle, then go to LOAD.
- LOAD: capture FIFO_DOUT into the shift register, clear counters, go to START.
- START: TX=0 for CLKS_PER_BIT cycles.
- DATA: TX = shift_reg[0]. Shift right every CLKS_PER_BIT cycles. Exactly DATA_W bits are sent, LSB first, using a 4-bit bit counter.
- STOP: TX=1 for CLKS_PER_BIT cycles. DONE=1 on the final cycle. Then go to IDLE.
- Frame latency: the START bit begins 2 cycles after IDLE detects the start condition. Minimum word period is (DATA_W+2)*CLKS_PER_BIT+3 cycles (+CLKS_PER_BIT with parity).
- Back-to-back operation: after STOP, one IDLE cycle re-evaluates ENABLE and FIFO_EMPTY. At most one RD_EN pulse is issued per frame.
- Empty FIFO: FIFO_RD_EN is never asserted while FIFO_EMPTY=1 in IDLE. FIFO_EMPTY is ignored outside IDLE.
- ENABLE dropping mid-frame: the current frame completes. No new pop is issued afterwards.
- Reset mid-frame: TX returns to 1 at the next edge. The word already popped is discarded, and there is no retry.
- FIFO_DOUT is not re-sampled after LOAD, so FIFO writes during a frame do not corrupt it.

Optional Feature:
Macro TX_PARITY_EN.
- Defined: a PARITY state follows DATA. TX = even parity (XOR of all DATA_W bits captured in LOAD) for CLKS_PER_BIT cycles. The frame is 13 bits.
- Undefined: DATA goes directly to STOP. The frame is 12 bits. No parity logic is synthesized.

Test Plan:
1. Reset: hold RST=0 for 3 edges with ENABLE=1 and FIFO_EMPTY=0 -> TX=1, FIFO_RD_EN=0, BUSY=0, DONE=0 throughout.
2. Single word 10'd32, CLKS_PER_BIT=4, no parity -> exactly one RD_EN pulse. TX bit sequence is 0 | 0,0,0,0,0,1,0,0,0,0 | 1, each bit held 4 cycles. DONE pulses once, 50 cycles after RD_EN.
3. FIFO preloaded with 32, 29, 53 and ENABLE held high -> exactly three RD_EN pulses, frames in order 32, 29, 53. One IDLE cycle between the DONE pulse and the next RD_EN. BUSY drops only after the third frame.
4. FIFO_EMPTY=1 and ENABLE=1 for 100 cycles -> no RD_EN pulse, TX stays 1, BUSY stays 0.
5. RST=0 asserted during the DATA bits of word 53 -> TX=1 and IDLE after that edge. After release with the FIFO empty, no frame is sent and DONE stays 0.
6. With TX_PARITY_EN defined, send word 10'd53 (1,0,1,0,1,1,0,0,0,0 LSB first) then 10'd29 -> parity bit 0 for 53, 0 for 29 (four ones each). Word 10'd7 -> parity bit 1. Frame is 13 bits.
